fir_sched: RTL and testbench
============================

FIR_SCHED -- requirements
Module: fir_sched

Interface
REQ-001 Parameter NUM_BANDS, default 5: number of FIR bands time-sharing one MAC/ROM engine.
REQ-002 Parameter RUN_CYC, default 1023: cycles `sequencing` stays high per band, covering 1021 taps plus engine pipeline.
REQ-003 clk  input  1: sole clock; all logic on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 valid  input  1: one-cycle strobe, new stereo sample present.
REQ-006 lft_in, rht_in  input  16 each, signed: incoming sample pair.
REQ-007 smpl_L, smpl_R  output  16 each, signed: held sample pair driven to the engine.
REQ-008 sequencing  output  1: engine run enable; low clears the engine accumulator and address.
REQ-009 band_sel  output  3: selects the coefficient ROM for the active band, 0..NUM_BANDS-1.
REQ-010 filt_L, filt_R  input  16 each: engine results.
REQ-011 band_L, band_R  output  16*NUM_BANDS each: captured per-band results, band b at bits [16b+15:16b].
REQ-012 busy  output  1: high in any state other than IDLE.
REQ-013 done  output  1: one-cycle pulse when all bands are captured.
REQ-014 overrun  output  1: sticky flag, set when a valid pulse is dropped.

Function
REQ-015 The FSM SHALL have four states: IDLE, CLR, RUN and CAPT.
REQ-016 In IDLE, valid=1 SHALL latch lft_in/rht_in into smpl_L/smpl_R, set band_sel=0, clear the cycle counter and enter CLR.
REQ-017 CLR SHALL last exactly 2 cycles with sequencing=0, then enter RUN.
REQ-018 RUN SHALL hold sequencing=1 for exactly RUN_CYC cycles, counted by a counter of width ceil(log2(RUN_CYC+1)), then enter CAPT.
REQ-019 CAPT SHALL last 1 cycle with sequencing=0 and, at its closing edge, copy filt_L/filt_R into band_L/band_R slot band_sel.
REQ-020 From CAPT, if band_sel<NUM_BANDS-1, the block SHALL increment band_sel and enter CLR; otherwise it SHALL enter IDLE.
REQ-021 done SHALL be 1 for the single cycle in which the FSM first occupies IDLE after the last CAPT.
REQ-022 smpl_L/smpl_R SHALL stay constant from latch until the next accepted valid.
REQ-023 band_sel SHALL be constant throughout CLR, RUN and CAPT of one band.
REQ-024 sequencing SHALL be 1 only in RUN.
REQ-025 Latency: with valid at edge k, sequencing SHALL first be high in the cycle after edge k+2, and done SHALL rise NUM_BANDS*(RUN_CYC+3) cycles after edge k.
REQ-026 A valid pulse while busy=1, including in the cycle done=1 is not applicable since done occurs in IDLE, SHALL be ignored for data and SHALL set overrun.
REQ-027 valid in the done cycle (IDLE) SHALL be accepted normally.
REQ-028 Slots not yet updated in the current frame SHALL retain their previous-frame values.
REQ-029 band_sel SHALL never exceed NUM_BANDS-1.
REQ-030 band_sel SHALL return to 0 only on acceptance of a new valid or on reset.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and drive sequencing=0, busy=0, done=0, overrun=0, band_sel=0, smpl_L=smpl_R=0, all band_L/band_R=0 and counter=0.
REQ-032 rst SHALL take priority over valid on the same edge.
REQ-033 rst asserted mid-RUN SHALL abort the frame with no capture, and sequencing SHALL be 0 in the cycle after that edge.
REQ-034 After reset, the first valid SHALL still pass through the 2-cycle CLR state.

Verification
REQ-035 Basic run with NUM_BANDS=2, RUN_CYC=4: valid with lft_in=0x1234, rht_in=0xFEDC -> smpl_L=0x1234, sequencing high 4 cycles twice, separated by CAPT plus 2 CLR cycles, and done at 14 cycles after the valid edge.
REQ-036 Capture: engine stub drives filt_L=0x0100+band_sel and filt_R=0x0200+band_sel -> band_L=0x0101_0100, band_R=0x0201_0200.
REQ-037 Overrun: second valid 5 cycles after the first -> overrun=1 and stays 1, smpl_L unchanged, frame completes normally.
REQ-038 Back-to-back: valid in the done cycle -> accepted, busy=1 next cycle, overrun stays 0.
REQ-039 Reset mid-RUN: rst at the second RUN cycle of band 1 -> next cycle all outputs are 0 and IDLE, and a later valid gives a full 14-cycle frame.
REQ-040 Default parameters: one valid -> each RUN lasts 1023 cycles, and done occurs 5130 cycles after the valid edge.

Source files
------------

// File: rtl/fir_sched_if.sv
// Bus bundle between the FIR band scheduler and its surroundings: sample
// input strobe, held samples and run control toward the shared MAC/ROM
// engine, engine results back, and per-band captured results out.
interface fir_sched_if #(
  parameter int NUM_BANDS = 5
);
  logic                        valid;
  logic signed [15:0]          lft_in;
  logic signed [15:0]          rht_in;
  logic signed [15:0]          smpl_L;
  logic signed [15:0]          smpl_R;
  logic                        sequencing;
  logic        [2:0]           band_sel;
  logic signed [15:0]          filt_L;
  logic signed [15:0]          filt_R;
  logic [16*NUM_BANDS-1:0]     band_L;
  logic [16*NUM_BANDS-1:0]     band_R;
  logic                        busy;
  logic                        done;
  logic                        overrun;

  // Scheduler side: consumes samples and engine results, drives everything else.
  modport slave (
    input  valid, lft_in, rht_in, filt_L, filt_R,
    output smpl_L, smpl_R, sequencing, band_sel, band_L, band_R, busy, done, overrun
  );

  // Environment side: sample source plus engine model.
  modport master (
    output valid, lft_in, rht_in, filt_L, filt_R,
    input  smpl_L, smpl_R, sequencing, band_sel, band_L, band_R, busy, done, overrun
  );
endinterface

// File: rtl/fir_sched.sv
// FIR band scheduler: on each accepted stereo sample, runs NUM_BANDS bands
// back to back through one shared MAC/ROM engine. Each band is a 2-cycle
// accumulator clear, RUN_CYC cycles of engine run, and a 1-cycle capture of
// the engine result into that band's slot. All outputs are registered.
module fir_sched #(
  parameter int NUM_BANDS = 5,
  parameter int RUN_CYC   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  fir_sched_if.slave  bus
);

  localparam int              CW        = $clog2(RUN_CYC + 1);
  localparam int              BW        = 16 * NUM_BANDS;
  localparam logic [CW-1:0]   CLR_LAST  = CW'(1);
  localparam logic [CW-1:0]   RUN_LAST  = CW'(RUN_CYC - 1);
  localparam logic [2:0]      LAST_BAND = 3'(NUM_BANDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         band_sel_q;
  logic signed [15:0] smpl_l_q;
  logic signed [15:0] smpl_r_q;
  logic [BW-1:0]      band_l_q;
  logic [BW-1:0]      band_r_q;
  logic [BW-1:0]      band_l_d;
  logic [BW-1:0]      band_r_d;
  logic               seq_q;
  logic               busy_q;
  logic               done_q;
  logic               ovr_q;

  // Result vectors with the active band's slot replaced by the engine output.
  always_comb begin
    band_l_d = band_l_q;
    band_r_d = band_r_q;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (band_sel_q == 3'(b)) begin
        band_l_d[16*b +: 16] = bus.filt_L;
        band_r_d[16*b +: 16] = bus.filt_R;
      end else begin
        band_l_d[16*b +: 16] = band_l_q[16*b +: 16];
        band_r_d[16*b +: 16] = band_r_q[16*b +: 16];
      end
    end
  end

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      band_sel_q <= 3'd0;
      smpl_l_q   <= 16'sd0;
      smpl_r_q   <= 16'sd0;
      band_l_q   <= '0;
      band_r_q   <= '0;
      seq_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A sample arriving mid-frame is dropped; remember that it happened.
      if (bus.valid && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          seq_q <= 1'b0;
          if (bus.valid) begin
            smpl_l_q   <= bus.lft_in;
            smpl_r_q   <= bus.rht_in;
            band_sel_q <= 3'd0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= CLR;
          end
        end
        CLR: begin
          if (cnt_q == CLR_LAST) begin
            cnt_q   <= '0;
            seq_q   <= 1'b1;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (cnt_q == RUN_LAST) begin
            cnt_q   <= '0;
            seq_q   <= 1'b0;
            state_q <= CAPT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        CAPT: begin
          band_l_q <= band_l_d;
          band_r_q <= band_r_d;
          if (band_sel_q != LAST_BAND) begin
            band_sel_q <= band_sel_q + 3'd1;
            state_q    <= CLR;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          seq_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.smpl_L     = smpl_l_q;
  assign bus.smpl_R     = smpl_r_q;
  assign bus.sequencing = seq_q;
  assign bus.band_sel   = band_sel_q;
  assign bus.band_L     = band_l_q;
  assign bus.band_R     = band_r_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: a small configuration (2 bands, 4-cycle run) for the
// directed scenarios and a default-parameter instance for full-frame timing.
module tb_fir_sched;

  localparam int NB_A  = 2;
  localparam int RUN_A = 4;
  localparam int PER_A = RUN_A + 3;
  localparam int LAT_A = NB_A * PER_A;
  localparam int NB_B  = 5;
  localparam int RUN_B = 1023;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic [15:0] stub_l;
  logic [15:0] stub_r;

  int checks   = 0;
  int failures = 0;

  fir_sched_if #(.NUM_BANDS(NB_A)) ifa ();
  fir_sched_if #(.NUM_BANDS(NB_B)) ifb ();

  fir_sched #(.NUM_BANDS(NB_A), .RUN_CYC(RUN_A)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  fir_sched #(.NUM_BANDS(NB_B), .RUN_CYC(RUN_B)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  // Engine stubs: result depends on the band being run.
  assign ifa.filt_L = stub_l + {13'd0, ifa.band_sel};
  assign ifa.filt_R = stub_r + {13'd0, ifa.band_sel};
  assign ifb.filt_L = 16'h0300 + {13'd0, ifb.band_sel};
  assign ifb.filt_R = 16'h0600 + {13'd0, ifb.band_sel};

  always #5 clk = ~clk;

  // Scoreboard for the small instance.
  logic [31:0] exp_bl_q[$];
  logic [31:0] exp_br_q[$];
  int          exp_lat_q[$];
  logic [15:0] cur_l;
  logic [15:0] cur_r;
  logic [31:0] prev_bl;
  logic [31:0] prev_br;
  logic        exp_ovr;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a();
    check("rst_seq", {ifa.sequencing}, 1'b0);
    check("rst_busy", {ifa.busy}, 1'b0);
    check("rst_done", {ifa.done}, 1'b0);
    check("rst_ovr", {ifa.overrun}, 1'b0);
    check("rst_bsel", {ifa.band_sel}, 3'd0);
    check("rst_smpl_l", {ifa.smpl_L}, 16'h0000);
    check("rst_smpl_r", {ifa.smpl_R}, 16'h0000);
    check("rst_band_l", {ifa.band_L}, 32'h0);
    check("rst_band_r", {ifa.band_R}, 32'h0);
  endtask

  // Present a sample at the current negedge and record what the frame must produce.
  task automatic drive_valid(input logic [15:0] l, input logic [15:0] r,
                             input logic [15:0] bl, input logic [15:0] br);
    stub_l     = bl;
    stub_r     = br;
    ifa.valid  = 1'b1;
    ifa.lft_in = l;
    ifa.rht_in = r;
    cur_l      = l;
    cur_r      = r;
    exp_bl_q.push_back({bl + 16'd1, bl});
    exp_br_q.push_back({br + 16'd1, br});
    exp_lat_q.push_back(LAT_A);
  endtask

  // Follow one frame cycle by cycle; n counts posedges since the accepting edge.
  task automatic run_frame(input int ovr_at, input int abort_at, input bit b2b,
                           input logic [15:0] nl, input logic [15:0] nr,
                           input logic [15:0] nbl, input logic [15:0] nbr);
    int p;
    logic [31:0] ebl;
    logic [31:0] ebr;
    ebl = exp_bl_q[0];
    ebr = exp_br_q[0];
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      ifa.valid = 1'b0;
      if (ovr_at >= 0 && n == ovr_at + 1) exp_ovr = 1'b1;
      p = n % PER_A;
      if (n < LAT_A) begin
        check("seq", {ifa.sequencing}, {(p >= 2 && p <= RUN_A + 1)});
        check("busy", {ifa.busy}, 1'b1);
        check("bsel", {ifa.band_sel}, 3'(n / PER_A));
        check("done_early", {ifa.done}, 1'b0);
        if (n < PER_A) check("slots_old", {ifa.band_L, ifa.band_R}, {prev_bl, prev_br});
        else check("slots_mix", {ifa.band_L, ifa.band_R},
                   {prev_bl[31:16], ebl[15:0], prev_br[31:16], ebr[15:0]});
      end
      check("smpl", {ifa.smpl_L, ifa.smpl_R}, {cur_l, cur_r});
      check("ovr", {ifa.overrun}, {exp_ovr});
      if (n == ovr_at) begin
        ifa.valid  = 1'b1;
        ifa.lft_in = 16'h5555;
        ifa.rht_in = 16'h6666;
      end
      if (n == abort_at) begin
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_reset_a();
        void'(exp_bl_q.pop_front());
        void'(exp_br_q.pop_front());
        void'(exp_lat_q.pop_front());
        exp_ovr = 1'b0;
        prev_bl = 32'h0;
        prev_br = 32'h0;
        cur_l   = 16'h0;
        cur_r   = 16'h0;
        return;
      end
      if (ifa.done === 1'b1) begin
        check("latency", 32'(n), 32'(exp_lat_q.pop_front()));
        check("band_l", {ifa.band_L}, {exp_bl_q.pop_front()});
        check("band_r", {ifa.band_R}, {exp_br_q.pop_front()});
        check("busy_done", {ifa.busy}, 1'b0);
        check("bsel_hold", {ifa.band_sel}, 3'(NB_A - 1));
        prev_bl = ebl;
        prev_br = ebr;
        if (b2b) drive_valid(nl, nr, nbl, nbr);
        return;
      end
    end
    check("done_timeout", 1'b0, 1'b1);
  endtask

  // Hard stop in case a wait never resolves.
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_hi;
    int first_lo;
    int hi_cnt;
    int done_n;
    logic [79:0] exp_b;
    clk = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    stub_l = 16'h0;
    stub_r = 16'h0;
    ifa.valid = 1'b0; ifa.lft_in = 16'h0; ifa.rht_in = 16'h0;
    ifb.valid = 1'b0; ifb.lft_in = 16'h0; ifb.rht_in = 16'h0;
    prev_bl = 32'h0; prev_br = 32'h0; exp_ovr = 1'b0;
    cur_l = 16'h0; cur_r = 16'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_a();
    rst_a = 1'b0;

    // Reset wins over a simultaneous valid.
    @(negedge clk);
    rst_a = 1'b1; ifa.valid = 1'b1; ifa.lft_in = 16'h7777; ifa.rht_in = 16'h8888;
    @(negedge clk);
    rst_a = 1'b0; ifa.valid = 1'b0;
    check_reset_a();

    // Basic frame with the 0x0100/0x0200 engine stub.
    @(negedge clk);
    drive_valid(16'h1234, 16'hFEDC, 16'h0100, 16'h0200);
    run_frame(-1, -1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Second valid five cycles in: dropped, overrun sticks, frame completes.
    @(negedge clk);
    drive_valid(16'h0AAA, 16'h0BBB, 16'h0400, 16'h0500);
    run_frame(4, -1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("ovr_sticky", {ifa.overrun}, 1'b1);

    // Clear overrun, then back-to-back frames with valid in the done cycle.
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    exp_ovr = 1'b0; prev_bl = 32'h0; prev_br = 32'h0; cur_l = 16'h0; cur_r = 16'h0;
    check_reset_a();
    drive_valid(16'h1111, 16'h2222, 16'h0A00, 16'h0B00);
    run_frame(-1, -1, 1'b1, 16'h3333, 16'h4444, 16'h0C00, 16'h0D00);
    run_frame(-1, -1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Reset during the second run cycle of band 1, then a clean frame.
    @(negedge clk);
    drive_valid(16'h5A5A, 16'hA5A5, 16'h0E00, 16'h0F00);
    run_frame(-1, PER_A + 3, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    drive_valid(16'h0123, 16'h0456, 16'h1000, 16'h2000);
    run_frame(-1, -1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Default parameters: full 5-band frame timing.
    rst_b = 1'b0;
    @(negedge clk);
    ifb.valid = 1'b1; ifb.lft_in = 16'h0042; ifb.rht_in = 16'h0043;
    first_hi = -1; first_lo = -1; hi_cnt = 0; done_n = -1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      ifb.valid = 1'b0;
      if (ifb.sequencing === 1'b1) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end else if (first_hi >= 0 && first_lo < 0) begin
        first_lo = i;
      end
      if (ifb.done === 1'b1) begin
        done_n = i;
        break;
      end
    end
    exp_b = '0;
    for (int b = 0; b < NB_B; b++) exp_b[16*b +: 16] = 16'h0300 + 16'(b);
    check("b_first_seq", 32'(first_hi), 32'd2);
    check("b_run_len", 32'(first_lo - first_hi), 32'(RUN_B));
    check("b_seq_total", 32'(hi_cnt), 32'(NB_B * RUN_B));
    check("b_done_lat", 32'(done_n), 32'd5130);
    check("b_band_l", ifb.band_L, exp_b);
    check("b_smpl_l", {ifb.smpl_L}, 16'h0042);
    check("b_busy", {ifb.busy}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
